// File: rtl/poly_voice_allocator.sv
// Polyphonic voice allocator: parses the MIDI byte stream into note events,
// then assigns notes to NUM_VOICES voices with retrigger, oldest-voice
// stealing (or dropping), note-off matching and all-notes-off.
//
// Parser states
//   state    | meaning
//   P_IDLE   | no running status; data bytes are ignored
//   P_DATA1  | running status held, waiting for first data byte
//   P_DATA2  | first data byte held, waiting for second data byte
module poly_voice_allocator #(
   parameter int NUM_VOICES   = 4,
   parameter int MIDI_CHANNEL = 0,
   parameter int OMNI         = 0,
   parameter int STEAL_MODE   = 1
) (
   input  logic                            clk100,
   input  logic                            rst_n,
   input  logic [7:0]                      midi_data,
   input  logic                            midi_valid,
   output logic [NUM_VOICES-1:0]           voice_gate,
   output logic [7*NUM_VOICES-1:0]         voice_note,
   output logic [7*NUM_VOICES-1:0]         voice_vel,
   output logic [NUM_VOICES-1:0]           voice_trig,
   output logic                            steal_pulse,
   output logic                            drop_pulse,
   output logic [$clog2(NUM_VOICES+1)-1:0] active_count
);

   localparam int CW = $clog2(NUM_VOICES+1);
   localparam int RW = $clog2(NUM_VOICES);
   localparam logic [3:0]    CHAN   = 4'(MIDI_CHANNEL);
   localparam logic [RW-1:0] OLDEST = RW'(NUM_VOICES-1);

   typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2} pstate_t;
   typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF, EV_ALLOFF} ev_t;

   pstate_t    pstate_q;
   logic [7:0] status_q;
   logic [6:0] data1_q;
   ev_t        ev_q;
   ev_t        ev_dec;
   logic [6:0] ev_note_q;
   logic [6:0] ev_vel_q;
   logic       ch_ok;

   logic [NUM_VOICES-1:0]           gate_q, gate_d;
   logic [NUM_VOICES-1:0][6:0]      note_q, note_d;
   logic [NUM_VOICES-1:0][6:0]      vel_q, vel_d;
   logic [NUM_VOICES-1:0][RW-1:0]   rank_q, rank_d;
   logic [NUM_VOICES-1:0]           trig_q, trig_d;
   logic                            steal_q, steal_d;
   logic                            drop_q, drop_d;
   logic [CW-1:0]                   cnt_q, cnt_d;

   logic          hit, free, go;
   logic [RW-1:0] hit_idx, free_idx, old_idx, v_idx;

   // Classify the message completed by the current (second) data byte.
   always_comb begin
      ev_dec = EV_NONE;
      ch_ok  = (OMNI != 0) || (status_q[3:0] == CHAN);
      if (ch_ok) begin
         case (status_q[7:4])
            4'h8:    ev_dec = EV_OFF;
            4'h9:    ev_dec = (midi_data[6:0] != 7'd0) ? EV_ON : EV_OFF;
            4'hB: begin
               if (data1_q == 7'd120 || data1_q == 7'd123) ev_dec = EV_ALLOFF;
            end
            default: ev_dec = EV_NONE;
         endcase
      end
   end

   // Byte parser with running status; emits a one-cycle registered event.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         pstate_q  <= P_IDLE;
         status_q  <= 8'h00;
         data1_q   <= 7'd0;
         ev_q      <= EV_NONE;
         ev_note_q <= 7'd0;
         ev_vel_q  <= 7'd0;
      end else begin
         ev_q <= EV_NONE;
         if (midi_valid) begin
            if (midi_data[7]) begin
               // Realtime bytes (F8-FF) fall through untouched.
               if (midi_data < 8'hF0) begin
                  status_q <= midi_data;
                  pstate_q <= P_DATA1;
               end else if (midi_data < 8'hF8) begin
                  status_q <= 8'h00;
                  pstate_q <= P_IDLE;
               end
            end else begin
               case (pstate_q)
                  P_DATA1: begin
                     data1_q  <= midi_data[6:0];
                     pstate_q <= P_DATA2;
                  end
                  P_DATA2: begin
                     ev_q      <= ev_dec;
                     ev_note_q <= data1_q;
                     ev_vel_q  <= midi_data[6:0];
                     pstate_q  <= P_DATA1;
                  end
                  default: pstate_q <= P_IDLE;
               endcase
            end
         end
      end
   end

   // Locate a voice already holding the note, the lowest free voice and the oldest voice.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      old_idx  = '0;
      for (int i = NUM_VOICES-1; i >= 0; i--) begin
         if (gate_q[i] && note_q[i] == ev_note_q) begin
            hit     = 1'b1;
            hit_idx = RW'(i);
         end
         if (!gate_q[i]) begin
            free     = 1'b1;
            free_idx = RW'(i);
         end
         if (rank_q[i] == OLDEST) old_idx = RW'(i);
      end
   end

   // Apply the pending event to the voice table.
   always_comb begin
      gate_d  = gate_q;
      note_d  = note_q;
      vel_d   = vel_q;
      rank_d  = rank_q;
      trig_d  = '0;
      steal_d = 1'b0;
      drop_d  = 1'b0;
      go      = 1'b0;
      v_idx   = '0;
      case (ev_q)
         EV_ON: begin
            if (hit) begin
               go    = 1'b1;
               v_idx = hit_idx;
            end else if (free) begin
               go    = 1'b1;
               v_idx = free_idx;
            end else if (STEAL_MODE != 0) begin
               go      = 1'b1;
               v_idx   = old_idx;
               steal_d = 1'b1;
            end else begin
               drop_d = 1'b1;
            end
            if (go) begin
               gate_d[v_idx] = 1'b1;
               note_d[v_idx] = ev_note_q;
               vel_d[v_idx]  = ev_vel_q;
               trig_d[v_idx] = 1'b1;
               // Age everything younger than the chosen voice, then make it newest.
               for (int u = 0; u < NUM_VOICES; u++) begin
                  if (rank_q[u] < rank_q[v_idx]) rank_d[u] = rank_q[u] + RW'(1);
               end
               rank_d[v_idx] = '0;
            end
         end
         EV_OFF: begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (gate_q[i] && note_q[i] == ev_note_q) gate_d[i] = 1'b0;
            end
         end
         EV_ALLOFF: gate_d = '0;
         default: ;
      endcase
   end

   // Population count of the next gate vector, registered alongside the gates.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < NUM_VOICES; i++) cnt_d = cnt_d + CW'(gate_d[i]);
   end

   // Voice table and pulse registers.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         gate_q  <= '0;
         note_q  <= '0;
         vel_q   <= '0;
         trig_q  <= '0;
         steal_q <= 1'b0;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= RW'(i);
      end else begin
         gate_q  <= gate_d;
         note_q  <= note_d;
         vel_q   <= vel_d;
         rank_q  <= rank_d;
         trig_q  <= trig_d;
         steal_q <= steal_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
      end
   end

   assign voice_gate   = gate_q;
   assign voice_note   = note_q;
   assign voice_vel    = vel_q;
   assign voice_trig   = trig_q;
   assign steal_pulse  = steal_q;
   assign drop_pulse   = drop_q;
   assign active_count = cnt_q;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Bench for poly_voice_allocator: table of MIDI messages with expected voice
// state on a stealing, channel-0 instance, plus hand sequences for drop mode
// with OMNI on a second instance and for reset in the middle of a message.
module tb_poly_voice_allocator;

   logic        clk100 = 1'b0;
   logic        rst_n;
   logic [7:0]  a_data, b_data;
   logic        a_valid, b_valid;

   logic [3:0]  a_gate, a_trig, b_gate, b_trig;
   logic [27:0] a_note, a_vel, b_note, b_vel;
   logic        a_steal, a_drop, b_steal, b_drop;
   logic [2:0]  a_cnt, b_cnt;

   always #5 clk100 = ~clk100;

   poly_voice_allocator #(.NUM_VOICES(4), .MIDI_CHANNEL(0), .OMNI(0), .STEAL_MODE(1)) dut_a (
      .clk100(clk100), .rst_n(rst_n), .midi_data(a_data), .midi_valid(a_valid),
      .voice_gate(a_gate), .voice_note(a_note), .voice_vel(a_vel), .voice_trig(a_trig),
      .steal_pulse(a_steal), .drop_pulse(a_drop), .active_count(a_cnt));

   poly_voice_allocator #(.NUM_VOICES(4), .MIDI_CHANNEL(3), .OMNI(1), .STEAL_MODE(0)) dut_b (
      .clk100(clk100), .rst_n(rst_n), .midi_data(b_data), .midi_valid(b_valid),
      .voice_gate(b_gate), .voice_note(b_note), .voice_vel(b_vel), .voice_trig(b_trig),
      .steal_pulse(b_steal), .drop_pulse(b_drop), .active_count(b_cnt));

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] msg;
      int          nb;
      logic [3:0]  gate;
      logic [3:0]  trig;
      logic        steal;
      logic        drop;
      logic [2:0]  cnt;
      int          vi;
      logic [6:0]  note;
      logic [6:0]  vel;
   } vec_t;

   vec_t vecs[28];

   function automatic vec_t mk(input logic [31:0] m, input int n, input logic [3:0] g,
                               input logic [3:0] t, input logic s, input logic d,
                               input logic [2:0] c, input int vi, input logic [6:0] nt,
                               input logic [6:0] vl);
      vec_t v;
      v.msg = m; v.nb = n; v.gate = g; v.trig = t; v.steal = s; v.drop = d;
      v.cnt = c; v.vi = vi; v.note = nt; v.vel = vl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input bit sel, input logic [7:0] b);
      @(negedge clk100);
      if (sel) begin b_data = b; b_valid = 1'b1; end
      else     begin a_data = b; a_valid = 1'b1; end
      @(negedge clk100);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic send_msg(input bit sel, input logic [31:0] m, input int n);
      logic [31:0] t;
      for (int k = 0; k < n; k++) begin
         t = m >> (8 * (3 - k));
         send(sel, t[7:0]);
      end
   endtask

   initial begin
      rst_n = 1'b0; a_data = 8'h00; a_valid = 1'b0; b_data = 8'h00; b_valid = 1'b0;

      //                msg           nb gate    trig    st dr cnt vi note  vel
      vecs[0]  = mk(32'h903C6400, 3, 4'b0001, 4'b0001, 0, 0, 1, 0, 60, 100);
      vecs[1]  = mk(32'h40500000, 2, 4'b0011, 4'b0010, 0, 0, 2, 1, 64, 80);
      vecs[2]  = mk(32'h3C000000, 2, 4'b0010, 4'b0000, 0, 0, 1, 0, 60, 100);
      vecs[3]  = mk(32'h80400000, 3, 4'b0000, 4'b0000, 0, 0, 0, 1, 64, 80);
      vecs[4]  = mk(32'h903C1000, 3, 4'b0001, 4'b0001, 0, 0, 1, 0, 60, 16);
      vecs[5]  = mk(32'h3E110000, 2, 4'b0011, 4'b0010, 0, 0, 2, 1, 62, 17);
      vecs[6]  = mk(32'h40120000, 2, 4'b0111, 4'b0100, 0, 0, 3, 2, 64, 18);
      vecs[7]  = mk(32'h41130000, 2, 4'b1111, 4'b1000, 0, 0, 4, 3, 65, 19);
      vecs[8]  = mk(32'h43140000, 2, 4'b1111, 4'b0001, 1, 0, 4, 0, 67, 20);
      vecs[9]  = mk(32'h45150000, 2, 4'b1111, 4'b0010, 1, 0, 4, 1, 69, 21);
      vecs[10] = mk(32'h80500000, 3, 4'b1111, 4'b0000, 0, 0, 4, 1, 69, 21);
      vecs[11] = mk(32'h90417F00, 3, 4'b1111, 4'b1000, 0, 0, 4, 3, 65, 127);
      vecs[12] = mk(32'h42160000, 2, 4'b1111, 4'b0100, 1, 0, 4, 2, 66, 22);
      vecs[13] = mk(32'h953C6400, 3, 4'b1111, 4'b0000, 0, 0, 4, 0, 67, 20);
      vecs[14] = mk(32'hB0780000, 3, 4'b0000, 4'b0000, 0, 0, 0, 2, 66, 22);
      vecs[15] = mk(32'h903C6400, 3, 4'b0001, 4'b0001, 0, 0, 1, 0, 60, 100);
      vecs[16] = mk(32'h903C0000, 3, 4'b0000, 4'b0000, 0, 0, 0, 0, 60, 100);
      vecs[17] = mk(32'h90F83C22, 4, 4'b0001, 4'b0001, 0, 0, 1, 0, 60, 34);
      vecs[18] = mk(32'h903CF040, 4, 4'b0001, 4'b0000, 0, 0, 1, 0, 60, 34);
      vecs[19] = mk(32'h3C000000, 2, 4'b0001, 4'b0000, 0, 0, 1, 0, 60, 34);
      vecs[20] = mk(32'h913C0000, 3, 4'b0001, 4'b0000, 0, 0, 1, 0, 60, 34);
      vecs[21] = mk(32'h803C0000, 3, 4'b0000, 4'b0000, 0, 0, 0, 0, 60, 34);
      vecs[22] = mk(32'h90300100, 3, 4'b0001, 4'b0001, 0, 0, 1, 0, 48, 1);
      vecs[23] = mk(32'h31020000, 2, 4'b0011, 4'b0010, 0, 0, 2, 1, 49, 2);
      vecs[24] = mk(32'h32030000, 2, 4'b0111, 4'b0100, 0, 0, 3, 2, 50, 3);
      vecs[25] = mk(32'hC0050600, 3, 4'b0111, 4'b0000, 0, 0, 3, 2, 50, 3);
      vecs[26] = mk(32'hB0076400, 3, 4'b0111, 4'b0000, 0, 0, 3, 2, 50, 3);
      vecs[27] = mk(32'hB07B0000, 3, 4'b0000, 4'b0000, 0, 0, 0, 2, 50, 3);

      #12;
      chk("rst_gate",  32'(a_gate),  32'h0);
      chk("rst_note",  32'(a_note),  32'h0);
      chk("rst_vel",   32'(a_vel),   32'h0);
      chk("rst_trig",  32'(a_trig),  32'h0);
      chk("rst_pulse", 32'({a_steal, a_drop}), 32'h0);
      chk("rst_cnt",   32'(a_cnt),   32'h0);
      chk("rst_b_gate", 32'(b_gate), 32'h0);
      @(negedge clk100);
      rst_n = 1'b1;

      for (int r = 0; r < 28; r++) begin
         send_msg(1'b0, vecs[r].msg, vecs[r].nb);
         @(negedge clk100);
         chk($sformatf("r%0d_gate", r),  32'(a_gate),  32'(vecs[r].gate));
         chk($sformatf("r%0d_trig", r),  32'(a_trig),  32'(vecs[r].trig));
         chk($sformatf("r%0d_steal", r), 32'(a_steal), 32'(vecs[r].steal));
         chk($sformatf("r%0d_drop", r),  32'(a_drop),  32'(vecs[r].drop));
         chk($sformatf("r%0d_cnt", r),   32'(a_cnt),   32'(vecs[r].cnt));
         chk($sformatf("r%0d_note", r),  32'(a_note[7*vecs[r].vi +: 7]), 32'(vecs[r].note));
         chk($sformatf("r%0d_vel", r),   32'(a_vel[7*vecs[r].vi +: 7]),  32'(vecs[r].vel));
         @(negedge clk100);
         chk($sformatf("r%0d_pulse_end", r), 32'({a_trig, a_steal, a_drop}), 32'h0);
         chk($sformatf("r%0d_gate_hold", r), 32'(a_gate), 32'(vecs[r].gate));
      end

      // Drop mode with OMNI: fill four voices, then a fifth note-on is dropped.
      send_msg(1'b1, 32'h933C0A00, 3);
      send_msg(1'b1, 32'h3E0B0000, 2);
      send_msg(1'b1, 32'h400C0000, 2);
      send_msg(1'b1, 32'h410D0000, 2);
      @(negedge clk100);
      chk("b_full_gate", 32'(b_gate), 32'hF);
      chk("b_full_cnt",  32'(b_cnt),  32'd4);
      send_msg(1'b1, 32'h95430E00, 3);
      @(negedge clk100);
      chk("b_drop",       32'(b_drop),  32'h1);
      chk("b_drop_steal", 32'(b_steal), 32'h0);
      chk("b_drop_trig",  32'(b_trig),  32'h0);
      chk("b_drop_gate",  32'(b_gate),  32'hF);
      chk("b_drop_note0", 32'(b_note[6:0]), 32'd60);
      chk("b_drop_vel0",  32'(b_vel[6:0]),  32'd10);
      @(negedge clk100);
      chk("b_drop_end",   32'(b_drop),  32'h0);
      send_msg(1'b1, 32'h853C0000, 3);
      @(negedge clk100);
      chk("b_off_gate", 32'(b_gate), 32'hE);
      chk("b_off_cnt",  32'(b_cnt),  32'd3);
      send_msg(1'b1, 32'h95430E00, 3);
      @(negedge clk100);
      chk("b_refill_gate",  32'(b_gate), 32'hF);
      chk("b_refill_trig",  32'(b_trig), 32'h1);
      chk("b_refill_note0", 32'(b_note[6:0]), 32'd67);
      chk("b_refill_drop",  32'(b_drop), 32'h0);

      // Reset in the middle of a message.
      send_msg(1'b0, 32'h903C6400, 3);
      @(negedge clk100);
      chk("t6_pre_gate", 32'(a_gate), 32'h1);
      send(1'b0, 8'h90);
      send(1'b0, 8'h3C);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_gate", 32'(a_gate), 32'h0);
      chk("t6_rst_note", 32'(a_note), 32'h0);
      chk("t6_rst_vel",  32'(a_vel),  32'h0);
      chk("t6_rst_cnt",  32'(a_cnt),  32'h0);
      @(negedge clk100);
      rst_n = 1'b1;
      send(1'b0, 8'h64);
      @(negedge clk100);
      chk("t6_orphan_gate", 32'(a_gate), 32'h0);
      chk("t6_orphan_trig", 32'(a_trig), 32'h0);
      send_msg(1'b0, 32'h903E5000, 3);
      @(negedge clk100);
      chk("t6_after_gate",  32'(a_gate), 32'h1);
      chk("t6_after_note0", 32'(a_note[6:0]), 32'd62);
      chk("t6_after_cnt",   32'(a_cnt),  32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
